// File: rtl/key_event_scheduler.sv
// Purpose : debounce N_KEYS raw push-buttons and turn each accepted press into one
//           pulse_o strobe, with a round-robin scheduler sharing the single event output.
// Latency : key_i rising before edge k -> pending after edge k+1+DB_CYCLES -> pulse_o
//           during the cycle after edge k+2+DB_CYCLES when the key wins arbitration.
// Backpressure: none; consumers must take every strobe. Contending keys wait in per-key
//           pending flags (worst case N_KEYS-1 cycles). A repeat event merges into a set flag.
// Ports   : clk, rst (async, active-low), key_i (raw levels, 1 = pressed),
//           pulse_o (1-cycle event), key_idx_o (index of last event, held),
//           stable_o (debounced levels), pending_o (accepted, not yet issued).
// Option  : define AUTOREPEAT_EN to add per-key auto-repeat (RPT_DELAY, RPT_PERIOD).
module key_event_scheduler #(
  parameter int N_KEYS     = 4,
  parameter int DB_CYCLES  = 16,
  parameter int RPT_DELAY  = 64,
  parameter int RPT_PERIOD = 16,
  parameter int IDX_W      = $clog2(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_i,
  output logic              pulse_o,
  output logic [IDX_W-1:0]  key_idx_o,
  output logic [N_KEYS-1:0] stable_o,
  output logic [N_KEYS-1:0] pending_o
);

  localparam int              CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM_ON  = 2'd1,
    ST_HELD    = 2'd2,
    ST_ARM_OFF = 2'd3
  } key_st_t;

  // Two-flop synchronizer; key_s is the only view of the keys the FSMs use.
  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] key_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      key_s <= '0;
    end else begin
      sync1 <= key_i;
      key_s <= sync1;
    end
  end

  logic [N_KEYS-1:0] ev_set;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_st_t          st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        st_q  <= ST_IDLE;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      press = 1'b0;
      unique case (st_q)
        ST_IDLE: begin
          if (key_s[g]) begin
            st_d  = ST_ARM_ON;
            cnt_d = CNT_W'(1);
          end
        end
        ST_ARM_ON: begin
          if (!key_s[g]) begin
            st_d  = ST_IDLE;
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            st_d  = ST_HELD;
            cnt_d = '0;
            press = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_HELD: begin
          if (!key_s[g]) begin
            st_d  = ST_ARM_OFF;
            cnt_d = CNT_W'(1);
          end
        end
        ST_ARM_OFF: begin
          // A bounce back high returns to HELD silently: releases never produce events.
          if (key_s[g]) begin
            st_d  = ST_HELD;
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            st_d  = ST_IDLE;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          st_d  = ST_IDLE;
          cnt_d = '0;
        end
      endcase
    end

    assign stable_o[g] = (st_q == ST_HELD) || (st_q == ST_ARM_OFF);

`ifdef AUTOREPEAT_EN
    // Repeat counter runs only in HELD and freezes in ARM_OFF, so a release bounce
    // delays the next repeat instead of restarting it. After the first repeat it is
    // parked at RPT_DELAY so later repeats come every RPT_PERIOD cycles.
    localparam int               RPT_W     = $clog2(RPT_DELAY + RPT_PERIOD);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(RPT_DELAY + RPT_PERIOD - 1);
    localparam logic [RPT_W-1:0] RPT_BASE  = RPT_W'(RPT_DELAY);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_fire;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) rpt_q <= '0;
      else      rpt_q <= rpt_d;
    end

    always_comb begin
      rpt_d    = rpt_q;
      rpt_fire = 1'b0;
      if (st_d == ST_IDLE) begin
        rpt_d = '0;
      end else if (st_q == ST_HELD) begin
        if (rpt_q == RPT_FIRST || rpt_q == RPT_NEXT) begin
          rpt_fire = 1'b1;
          rpt_d    = RPT_BASE;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
      end
    end

    assign ev_set[g] = press | rpt_fire;
`else
    assign ev_set[g] = press;
`endif
  end

  // Round-robin pick: lowest pending index at or above rr_ptr, else lowest overall.
  logic [IDX_W-1:0]  rr_ptr;
  logic [N_KEYS-1:0] pending_q;
  logic [N_KEYS-1:0] hi_mask;
  logic [N_KEYS-1:0] hi_pend;
  logic [N_KEYS-1:0] gnt_mask;
  logic [IDX_W-1:0]  gnt_idx;
  logic [IDX_W-1:0]  rr_next;
  logic              gnt_vld;

  always_comb begin
    hi_mask  = '0;
    gnt_idx  = '0;
    gnt_mask = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      hi_mask[i] = (IDX_W'(i) >= rr_ptr);
    end
    hi_pend = pending_q & hi_mask;
    gnt_vld = |pending_q;
    if (|hi_pend) begin
      for (int i = N_KEYS - 1; i >= 0; i--) begin
        if (hi_pend[i]) gnt_idx = IDX_W'(i);
      end
    end else begin
      for (int i = N_KEYS - 1; i >= 0; i--) begin
        if (pending_q[i]) gnt_idx = IDX_W'(i);
      end
    end
    if (gnt_vld) gnt_mask[gnt_idx] = 1'b1;
    rr_next = (gnt_idx == IDX_W'(N_KEYS - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      pulse_o   <= 1'b0;
      key_idx_o <= '0;
      rr_ptr    <= '0;
    end else begin
      // New event on the bit being granted this edge survives (set wins).
      pending_q <= (pending_q & ~gnt_mask) | ev_set;
      pulse_o   <= gnt_vld;
      if (gnt_vld) begin
        key_idx_o <= gnt_idx;
        rr_ptr    <= rr_next;
      end
    end
  end

  assign pending_o = pending_q;

endmodule
